// File: rtl/boid_frame_scheduler_pkg.sv
// Shared types and sizing helpers for the boid frame scheduler.
package boid_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} fsm_state_t;

  function automatic int addr_width(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boid_frame_scheduler_if.sv
// CPU boid-write bus and display-RAM write bus of the frame scheduler.
interface boid_frame_scheduler_if #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int SEL_WIDTH  = 5,
  parameter int ADDR_WIDTH = 19
);
  logic                  cpu_we;
  logic [SEL_WIDTH-1:0]  cpu_sel;
  logic [X_WIDTH-1:0]    cpu_x;
  logic [Y_WIDTH-1:0]    cpu_y;
  logic                  cpu_valid;
  logic                  ram_clear;
  logic                  pix_we;
  logic [ADDR_WIDTH-1:0] pix_addr;

  modport master (
    output cpu_we, cpu_sel, cpu_x, cpu_y, cpu_valid,
    input  ram_clear, pix_we, pix_addr
  );

  modport slave (
    input  cpu_we, cpu_sel, cpu_x, cpu_y, cpu_valid,
    output ram_clear, pix_we, pix_addr
  );
endinterface

// File: rtl/boid_frame_scheduler_pos_table.sv
// Boid position register file: one write port, one asynchronous read port.
module boid_pos_table #(
  parameter int NUM_BOIDS = 32,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 9,
  parameter int SEL_WIDTH = 5
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         we,
  input  logic [SEL_WIDTH-1:0]         wr_sel,
  input  logic [X_WIDTH+Y_WIDTH:0]     wr_data,
  input  logic [SEL_WIDTH-1:0]         rd_sel,
  output logic [X_WIDTH+Y_WIDTH:0]     rd_data
);

  logic [X_WIDTH+Y_WIDTH:0] mem [NUM_BOIDS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BOIDS; i++) mem[i] <= '0;
    end else if (we && (32'(wr_sel) < NUM_BOIDS)) begin
      mem[wr_sel] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_sel) < NUM_BOIDS) ? mem[rd_sel] : '0;

endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame boid rasteriser: clears the display RAM, then emits one write per
// on-screen pixel of a SPRITE x SPRITE square for every valid boid.
//
// state | meaning
// IDLE  | waiting for frame_end
// CLEAR | one-cycle ram_clear pulse
// DRAW  | one slot per cycle over (b, dy, dx)
// FLUSH | last registered pixel drains; done follows
module boid_frame_scheduler
  import boid_pkg::*;
#(
  parameter int NUM_BOIDS  = 32,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int SPRITE     = 2,
  parameter int ADDR_WIDTH = addr_width(H_RES, V_RES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ovr_clr,
  input  logic                   frame_end,
  boid_frame_scheduler_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int SEL_WIDTH = idx_width(NUM_BOIDS);
  localparam int D_WIDTH   = idx_width(SPRITE);
  localparam int EW        = 1 + X_WIDTH + Y_WIDTH;
  localparam logic [SEL_WIDTH-1:0] B_LAST = SEL_WIDTH'(NUM_BOIDS - 1);
  localparam logic [D_WIDTH-1:0]   D_LAST = D_WIDTH'(SPRITE - 1);
  localparam logic [X_WIDTH:0]     H_LIM  = (X_WIDTH + 1)'(H_RES);
  localparam logic [Y_WIDTH:0]     V_LIM  = (Y_WIDTH + 1)'(V_RES);

  fsm_state_t state, state_nxt;
  logic [SEL_WIDTH-1:0] b_cnt;
  logic [D_WIDTH-1:0]   dx, dy;
  logic                 drawing, first_slot, last_slot, on_screen;
  logic [EW-1:0]        rd_data, held, cur;
  logic [X_WIDTH:0]     px;
  logic [Y_WIDTH:0]     py;
  logic [ADDR_WIDTH-1:0] addr_calc;

  boid_pos_table #(
    .NUM_BOIDS (NUM_BOIDS),
    .X_WIDTH   (X_WIDTH),
    .Y_WIDTH   (Y_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_table (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (bus.cpu_we),
    .wr_sel  (bus.cpu_sel),
    .wr_data ({bus.cpu_valid, bus.cpu_x, bus.cpu_y}),
    .rd_sel  (b_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  assign last_slot = (b_cnt == B_LAST) && (dy == D_LAST) && (dx == D_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (frame_end) state_nxt = CLEAR;
      CLEAR: state_nxt = DRAW;
      DRAW:  if (last_slot) state_nxt = FLUSH;
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_clear = (state == CLEAR);
    busy          = (state != IDLE);
    drawing       = (state == DRAW);
  end

  // The table is read live on a boid's first slot so late CPU writes to
  // boids not yet reached still land in this frame.
  assign first_slot = (dx == '0) && (dy == '0);
  assign cur        = first_slot ? rd_data : held;
  assign px         = {1'b0, cur[Y_WIDTH +: X_WIDTH]} + (X_WIDTH + 1)'(dx);
  assign py         = {1'b0, cur[Y_WIDTH-1:0]} + (Y_WIDTH + 1)'(dy);
  assign on_screen  = drawing && cur[EW-1] && (px < H_LIM) && (py < V_LIM);
  assign addr_calc  = ADDR_WIDTH'(py) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(px);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_cnt <= '0;
      dx    <= '0;
      dy    <= '0;
      held  <= '0;
    end else if (!drawing) begin
      b_cnt <= '0;
      dx    <= '0;
      dy    <= '0;
    end else begin
      if (first_slot) held <= rd_data;
      if (dx == D_LAST) begin
        dx <= '0;
        if (dy == D_LAST) begin
          dy    <= '0;
          b_cnt <= b_cnt + SEL_WIDTH'(1);
        end else begin
          dy <= dy + D_WIDTH'(1);
        end
      end else begin
        dx <= dx + D_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.pix_we   <= 1'b0;
      bus.pix_addr <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      bus.pix_we <= on_screen;
      if (on_screen) bus.pix_addr <= addr_calc;
      done <= (state == FLUSH);
      if (frame_end && busy) overrun <= 1'b1;
      else if (ovr_clr)      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/boid_frame_scheduler.md
# boid_frame_scheduler

Per-frame boid rasteriser: holds the CPU-written position and valid bit of up to NUM_BOIDS boids, and on each VGA end-of-frame pulse it clears the boid display RAM. It then walks every boid and emits one display-RAM write per on-screen pixel of a SPRITE×SPRITE square. It sits between the CPU's boid-write registers and the resettable boid display RAM, replacing the per-boid BPU array and the ad-hoc frame loop with one parametrised, deterministic engine.

## Interface
- NUM_BOIDS, 32, boid slots; any value ≥1.
- X_WIDTH, 10, x coordinate width.
- Y_WIDTH, 9, y coordinate width.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- SPRITE, 2, side length of the square drawn per boid; ≥1.
- ADDR_WIDTH, $clog2(H_RES*V_RES), display RAM address width.

Ports:
- clock  in  1  system clock; the only clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cpu_we  in  1  write one boid slot this cycle.
- cpu_sel  in  $clog2(NUM_BOIDS) (min 1)  slot index; indices ≥ NUM_BOIDS are ignored.
- cpu_x  in  X_WIDTH  boid x.
- cpu_y  in  Y_WIDTH  boid y.
- cpu_valid  in  1  slot is drawn when 1.
- ovr_clr  in  1  clears overrun.
- frame_end  in  1  one-cycle end-of-frame pulse from VGA controller.
- ram_clear  out  1  one-cycle pulse to the display RAM reset/switch input.
- pix_we  out  1  display RAM write enable; write data is implicitly 1.
- pix_addr  out  ADDR_WIDTH  pixel address, y*H_RES + x.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame is completely written.
- overrun  out  1  sticky: frame_end arrived while busy.

## Operation
- Position table: NUM_BOIDS entries of {valid, x, y}. A cpu_we write takes effect at the next edge. Reset clears all entries to 0 and invalid.
- FSM states:
  - IDLE: frame_end → CLEAR.
  - CLEAR: 1 cycle, ram_clear=1 → DRAW.
  - DRAW: counters (b, dy, dx) start at 0. dx is innermost, then dy, then b. Advance one slot per cycle for NUM_BOIDS·SPRITE² cycles. After the final slot → FLUSH.
  - FLUSH: 1 cycle, drains the address register → IDLE, done=1 on entry to IDLE.
- A boid's {valid, x, y} is latched in the slot with dx=dy=0 and used for all of that boid's slots. A CPU write to boid b after that latch affects the next frame only. Writes to later boids affect the current frame.
- Per slot, compute px=x+dx and py=y+dy in widths X_WIDTH+1 and Y_WIDTH+1, so there is no wrap.
- pix_we=1 iff valid ∧ px<H_RES ∧ py<V_RES. In all other cases pix_we=0 and pix_addr holds its last value.
- The slot count is fixed regardless of valid or clipping, so frame latency is deterministic.
- frame_end while busy: ignored and overrun set. ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Simultaneous cpu_we and frame_end: the write lands first. It is visible to the frame if it is not for a boid already latched, which is always the case at frame start.

## Timing
- frame_end sampled high at edge k (IDLE): ram_clear and busy are high in cycle k+1.
- DRAW slots are issued in cycles k+2 … k+1+NUM_BOIDS·SPRITE².
- pix_we/pix_addr are registered, appearing one cycle after their slot, in cycles k+3 … k+2+NUM_BOIDS·SPRITE².
- busy is high in cycles k+1 … k+2+NUM_BOIDS·SPRITE². done pulses and busy=0 in cycle k+3+NUM_BOIDS·SPRITE².
- A new frame_end is accepted in the done cycle.
- Reset values: ram_clear=0, pix_we=0, pix_addr=0, busy=0, done=0, overrun=0, FSM=IDLE, counters 0.
- Reset asserted mid-frame forces all of these immediately (asynchronous), with no partial pulses after release.

## Structure
- Shared package boid_pkg: H_RES/V_RES defaults, fsm state enum {IDLE, CLEAR, DRAW, FLUSH}, addr-width helper function.
- Sub-module boid_pos_table: NUM_BOIDS×(1+X_WIDTH+Y_WIDTH) register file, one write port, one asynchronous read port, async active-low reset.
- The y*H_RES multiply lives in the registered address stage.

## Test plan
Unless stated, NUM_BOIDS=4, SPRITE=2, 640×480.
- Reset: hold reset_n=0 → all outputs 0; after release with no frame_end, pix_we never rises.
- Single boid: boid 1 written (10,20,valid), others invalid. frame_end at edge k → ram_clear in cycle k+1. Exactly 4 writes: 12810, 12811, 13450, 13451 (in that order). done at k+19.
- Clipping: boid 0 at (639,479) valid → exactly one write, addr 307199. Boid 2 at (700,10) → no write.
- Overrun: frame_end again 5 cycles after the first → ignored, done timing unchanged, overrun=1 until ovr_clr → 0.
- Mid-frame CPU writes during boid 0 drawing:
  - Writing boid 0 → the old coordinates are drawn this frame and the new ones next frame.
  - Writing boid 3 → the new coordinates are drawn this frame.
- Reset mid-DRAW → outputs 0 at once. The next frame_end after release produces a full, correct frame with the table cleared (no writes).
